// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC, a
// variable-latency ready/valid request to instruction memory, and the IF/ID
// pipeline register that feeds decode. It applies redirects from decode
// (j/jal/jr via PCSrc) and EX (taken beq), plus hazard-unit stall and flush.
//
// Optional build macro: IF_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt.
//
// Ports:
//   clk            pipeline clock
//   reset          asynchronous, active-low reset
//   stall_i        hold PC and IF/ID (load-use)
//   flush_i        force a bubble into IF/ID (overrides stall)
//   PCSrc          00 seq, 01 j/jal, 10 jr, 11 treated as seq
//   jump_target    j/jal target from decode
//   jr_target      forwarded rs value from decode
//   branch_taken   EX resolved a taken beq
//   branch_target  EX branch target
//   imem_req       fetch request valid
//   imem_addr      fetch address (word aligned)
//   imem_ready     memory accepts request and returns data this cycle
//   imem_rdata     instruction, valid when imem_req & imem_ready
//   IR             IF/ID instruction
//   PC_plus4       IF/ID PC+4
//   id_valid       IF/ID holds a real instruction
//   perf_fetch_cnt (IF_PERF_CNT_EN) instructions loaded into IF/ID
//   perf_drop_cnt  (IF_PERF_CNT_EN) discarded responses / dropped buffers
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] PC_plus4,
  output logic        id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DROP  = 2'd1;  // waiting on a stale request
  localparam logic [1:0] S_HOLD  = 2'd2;  // fetched word parked during stall

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] bufpc4_q, bufpc4_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        run_q;   // low until the first clock after reset release

  logic        jredir, redirect, accept, deliver, drop_evt;
  logic [31:0] target_raw, target, pc_plus4, dlv_ir, dlv_pc4;

  // A decode jump only counts when decode holds a real, non-stalled instr.
  assign jredir   = ((PCSrc == 2'b01) || (PCSrc == 2'b10)) && valid_q && !stall_i;
  assign redirect = branch_taken || jredir;

  // EX branch is older than the decode jump, so it wins.
  assign target_raw = branch_taken      ? branch_target :
                      (PCSrc == 2'b01)  ? jump_target   : jr_target;
  assign target     = {target_raw[31:2], 2'b00};

  assign imem_req  = run_q && (state_q != S_HOLD);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ready;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    buf_d    = buf_q;
    bufpc4_d = bufpc4_q;
    deliver  = 1'b0;
    drop_evt = 1'b0;
    dlv_ir   = imem_rdata;
    dlv_pc4  = pc_plus4;
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          if (redirect) begin
            pc_d     = target;
            drop_evt = 1'b1;
          end else if (!stall_i) begin
            deliver = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            buf_d    = imem_rdata;
            bufpc4_d = pc_plus4;
            pc_d     = pc_plus4;
            state_d  = S_HOLD;
          end
        end else if (redirect) begin
          // Address must stay stable until the memory answers.
          pend_d  = target;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect) pend_d = target;
        if (accept) begin
          pc_d     = redirect ? target : pend_q;
          drop_evt = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_HOLD: begin
        dlv_ir  = buf_q;
        dlv_pc4 = bufpc4_q;
        if (redirect) begin
          pc_d     = target;
          drop_evt = 1'b1;
          state_d  = S_FETCH;
        end else if (!stall_i) begin
          deliver = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // IF/ID: flush > stall > delivery > bubble.
  always_comb begin
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      ir_d    = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      if (deliver) begin
        ir_d    = dlv_ir;
        pc4_d   = dlv_pc4;
        valid_d = 1'b1;
      end else begin
        ir_d    = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      pend_q   <= RESET_PC;
      buf_q    <= NOP_INSTR;
      bufpc4_q <= 32'd0;
      ir_q     <= NOP_INSTR;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      buf_q    <= buf_d;
      bufpc4_q <= bufpc4_d;
      ir_q     <= ir_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      run_q    <= 1'b1;
    end
  end

  assign IR       = ir_q;
  assign PC_plus4 = pc4_q;
  assign id_valid = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, drop_cnt_q;
  logic        fetch_evt;

  // A delivery is only kept when not flushed (stall already excludes it).
  assign fetch_evt = deliver && !flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'd0;
      drop_cnt_q  <= 32'd0;
    end else begin
      if (fetch_evt && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (drop_evt && (drop_cnt_q != 32'hFFFF_FFFF))   drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop_evt;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC register and a ready/valid handshake to instruction memory that tolerates variable latency.
- Owns the IF/ID pipeline register whose IR output feeds decode.
- Applies redirects from decode (j/jal/jr via PCSrc) and from EX (taken beq), plus hazard-unit stall and flush.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, IR value for a bubble (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- stall_i  in  1  hazard unit: hold PC and IF/ID (load-use)
- flush_i  in  1  hazard unit: force a bubble into IF/ID
- PCSrc  in  2  from decode: 00 seq, 01 j/jal, 10 jr, 11 reserved (treated as 00)
- jump_target  in  32  {PC_plus4[31:28], IR[25:0], 2'b00}, computed in decode
- jr_target  in  32  forwarded rs value from decode
- branch_taken  in  1  from EX: beq resolved taken
- branch_target  in  32  from EX
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction, valid when imem_req & imem_ready
- IR  out  32  IF/ID instruction to decode
- PC_plus4  out  32  IF/ID PC+4
- id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, state=FETCH, IR=NOP_INSTR, PC_plus4=0, id_valid=0, buffer empty. imem_req=0 while reset is asserted; imem_req=1 from the first clock after release.
- Redirect request:
  - jredir = (PCSrc==01 | PCSrc==10) & id_valid & ~stall_i.
  - redirect = branch_taken | jredir.
  - Target: branch_taken ? branch_target : PCSrc==01 ? jump_target : jr_target. An EX branch is older than the decode jump and always wins.
- imem_addr = PC in FETCH and DROP. The address must be held stable while imem_req=1 and imem_ready=0.
- FSM states: FETCH, DROP, HOLD.
  - FETCH (imem_req=1):
    - ready & redirect: discard data; PC<=target; stay FETCH.
    - ready & ~redirect & ~stall_i: deliver data to IF/ID; PC<=PC+4; stay FETCH.
    - ready & ~redirect & stall_i: buffer<=rdata, bufpc4<=PC+4; PC<=PC+4; go HOLD.
    - ~ready & redirect: pend<=target; go DROP.
    - ~ready & ~redirect: stay FETCH.
  - DROP (imem_req=1, addr=old PC):
    - A further redirect overwrites pend.
    - On ready: discard data; PC<=pend; go FETCH.
  - HOLD (imem_req=0):
    - redirect: drop buffer; PC<=target; go FETCH.
    - ~stall_i: deliver buffer to IF/ID; go FETCH.
- IF/ID update, in priority order:
  - flush_i: IR<=NOP_INSTR, id_valid<=0; PC_plus4 don't-care, held. Flush overrides stall.
  - stall_i: hold all.
  - Delivery this cycle: IR, PC_plus4 loaded, id_valid<=1.
  - Otherwise: bubble (IR<=NOP_INSTR, id_valid<=0).
- Latency: with imem_ready tied 1 and no hazards, one instruction per cycle. The instruction fetched at cycle n appears on IR at n+1.
- Arithmetic: PC+4 wraps modulo 2^32. The target's low 2 bits are forced to 00.
- Simultaneous branch_taken and flush_i: both are applied. Redirect updates PC; flush clears IF/ID.
- Reset mid-request: any outstanding request is abandoned. The memory side must tolerate imem_req dropping.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt[31:0] and perf_drop_cnt[31:0].
  - perf_fetch_cnt counts cycles where id_valid is newly loaded with 1.
  - perf_drop_cnt counts discarded imem responses (FETCH ready&redirect, DROP ready) and dropped HOLD buffers.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset release, imem_ready=1, rdata=addr: imem_addr sequence 0x00400000, 0x00400004, ...; IR=0x00400000 and PC_plus4=0x00400004 one cycle after the first request.
- Stall with ready=1: stall_i high 2 cycles at PC 0x00400008. IR/id_valid held; state goes HOLD with imem_req=0. On release, IR=instr@0x00400008, then fetch resumes at 0x0040000C.
- Jump: PCSrc=01, jump_target=0x00400100 with id_valid=1. The next imem_addr is 0x00400100; the in-flight response is discarded; IF/ID gets a bubble.
- Redirect during wait: imem_ready=0 for 3 cycles at 0x00400010; branch_taken pulses with target 0x00400040. imem_addr stays 0x00400010 until ready; that data is discarded; the next request is 0x00400040.
- Branch beats jump: branch_taken=1 (0x00400200) and PCSrc=10 (jr_target 0x00400300) in the same cycle. The next address is 0x00400200.
- Flush during stall: flush_i=1, stall_i=1. IR becomes 0x00000000 and id_valid=0 next cycle; PC is unchanged.
